mux_nt1_seq: RTL and testbench



---
 rtl/mux_nt1_seq_pkg.sv | 28 ++
 rtl/mux_nt1_seq_if.sv | 39 +++
 rtl/mux_nt1_nb.sv | 19 +
 rtl/mux_nt1_seq.sv | 146 ++++++++++++++
 tb/tb_mux_nt1_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mux_nt1_seq_pkg.sv
// Shared types and constants for the N:1 registered scan multiplexer.
// MUX_NT1_SEQ_MASK_EN adds the enabled-channel search used by masked scans.
package mux_nt1_seq_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_SCAN = 1'b1;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

`ifdef MUX_NT1_SEQ_MASK_EN
   localparam int unsigned MASK_MAX_N = 64;
   typedef logic [MASK_MAX_N-1:0] mask_t;

   // Lowest enabled channel at or above 'from'; MASK_MAX_N when none remain.
   function automatic int unsigned next_en(input mask_t mask, input int unsigned from);
      int unsigned res;
      res = MASK_MAX_N;
      for (int unsigned i = 0; i < MASK_MAX_N; i++) begin
         if (mask[i] && (i >= from) && (res == MASK_MAX_N)) res = i;
      end
      return res;
   endfunction
`endif

endpackage

// File: rtl/mux_nt1_seq_if.sv
// Bus bundle between the sort datapath and mux_nt1_seq.
// MUX_NT1_SEQ_MASK_EN adds the per-channel scan enable.
interface mux_nt1_seq_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
);
   localparam int unsigned SW = $clog2(N);

   logic          mode;
   logic [SW-1:0] sel;
   logic [N*W-1:0] d_in;
   logic          start;
   logic          ready;
   logic [W-1:0]  d_out;
   logic [SW-1:0] ch_out;
   logic          valid;
   logic          last;
   logic          busy;
`ifdef MUX_NT1_SEQ_MASK_EN
   logic [N-1:0]  en_mask;
`endif

   modport master (
      output mode, sel, d_in, start, ready,
`ifdef MUX_NT1_SEQ_MASK_EN
      output en_mask,
`endif
      input  d_out, ch_out, valid, last, busy
   );

   modport slave (
      input  mode, sel, d_in, start, ready,
`ifdef MUX_NT1_SEQ_MASK_EN
      input  en_mask,
`endif
      output d_out, ch_out, valid, last, busy
   );

endinterface

// File: rtl/mux_nt1_nb.sv
// Combinational N:1, W-bit channel selector; out-of-range select yields zero.
module mux_nt1_nb #(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] d_in,
   output logic [W-1:0]   y_c
);

   always_comb begin
      y_c = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (sel == SW'(k)) y_c = d_in[k*W +: W];
      end
   end

endmodule

// File: rtl/mux_nt1_seq.sv
// Registered N:1 multiplexer with direct-select and handshaked scan modes.
// MUX_NT1_SEQ_MASK_EN restricts scans to channels enabled in en_mask.
module mux_nt1_seq
   import mux_nt1_seq_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_nt1_seq_if.slave bus
);

   localparam int unsigned SW = $clog2(N);

   state_t        state_q, state_d;
   logic [W-1:0]  d_q, d_d;
   logic [SW-1:0] ch_q, ch_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          busy_q, busy_d;

   logic [SW-1:0] mux_sel_c;
   logic [W-1:0]  mux_y_c;
   logic [SW-1:0] first_c, nxt_c;
   logic          first_last_c, nxt_last_c, can_start_c;

`ifdef MUX_NT1_SEQ_MASK_EN
   logic [N-1:0]  mask_q, mask_d;
   int unsigned   first_idx_c, nxt_idx_c;

   // Scan order from the live mask at start, from the captured mask afterwards.
   always_comb begin
      first_idx_c  = next_en(mask_t'(bus.en_mask), 32'd0);
      nxt_idx_c    = next_en(mask_t'(mask_q), 32'(ch_q) + 32'd1);
      first_c      = SW'(first_idx_c);
      nxt_c        = SW'(nxt_idx_c);
      first_last_c = (next_en(mask_t'(bus.en_mask), first_idx_c + 32'd1) == MASK_MAX_N);
      nxt_last_c   = (next_en(mask_t'(mask_q), nxt_idx_c + 32'd1) == MASK_MAX_N);
      can_start_c  = |bus.en_mask;
   end
`else
   always_comb begin
      first_c      = '0;
      nxt_c        = SW'(32'(ch_q) + 32'd1);
      first_last_c = 1'b0;
      nxt_last_c   = ((32'(ch_q) + 32'd1) == (N - 32'd1));
      can_start_c  = 1'b1;
   end
`endif

   mux_nt1_nb #(.N(N), .W(W), .SW(SW)) u_mux (
      .sel  (mux_sel_c),
      .d_in (bus.d_in),
      .y_c  (mux_y_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d   = state_q;
      d_d       = d_q;
      ch_d      = ch_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      mux_sel_c = nxt_c;
`ifdef MUX_NT1_SEQ_MASK_EN
      mask_d    = mask_q;
`endif
      case (state_q)
         ST_IDLE: begin
            last_d = 1'b0;
            if (bus.mode == MODE_DIRECT) begin
               mux_sel_c = bus.sel;
               d_d       = mux_y_c;
               ch_d      = bus.sel;
               valid_d   = (32'(bus.sel) < N);
            end else if (bus.start && can_start_c) begin
               mux_sel_c = first_c;
               d_d       = mux_y_c;
               ch_d      = first_c;
               valid_d   = 1'b1;
               last_d    = first_last_c;
               busy_d    = 1'b1;
               state_d   = ST_SCAN;
`ifdef MUX_NT1_SEQ_MASK_EN
               mask_d    = bus.en_mask;
`endif
            end else begin
               valid_d = 1'b0;
            end
         end
         ST_SCAN: begin
            if (valid_q && bus.ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  d_d    = mux_y_c;
                  ch_d   = nxt_c;
                  last_d = nxt_last_c;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MUX_NT1_SEQ_MASK_EN
         mask_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
`ifdef MUX_NT1_SEQ_MASK_EN
         mask_q  <= mask_d;
`endif
      end
   end

   assign bus.d_out  = d_q;
   assign bus.ch_out = ch_q;
   assign bus.valid  = valid_q;
   assign bus.last   = last_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux_nt1_seq.sv
// Directed bench for mux_nt1_seq at N=4 and N=5 (W=8).
// Mask steps compile in when MUX_NT1_SEQ_MASK_EN is defined.
module tb_mux_nt1_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mux_nt1_seq_if #(.N(4), .W(8)) b4 ();
   mux_nt1_seq_if #(.N(5), .W(8)) b5 ();

   mux_nt1_seq #(.N(4), .W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
   mux_nt1_seq #(.N(5), .W(8)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [31:0] ed, input logic [31:0] ech,
                       input logic ev, input logic el, input logic eb);
      chk({tag, ".d_out"},  32'(b4.d_out),  ed);
      chk({tag, ".ch_out"}, 32'(b4.ch_out), ech);
      chk({tag, ".valid"},  32'(b4.valid),  32'(ev));
      chk({tag, ".last"},   32'(b4.last),   32'(el));
      chk({tag, ".busy"},   32'(b4.busy),   32'(eb));
   endtask

   task automatic chk5(input string tag, input logic [31:0] ed, input logic [31:0] ech,
                       input logic ev, input logic el, input logic eb);
      chk({tag, ".d_out"},  32'(b5.d_out),  ed);
      chk({tag, ".ch_out"}, 32'(b5.ch_out), ech);
      chk({tag, ".valid"},  32'(b5.valid),  32'(ev));
      chk({tag, ".last"},   32'(b5.last),   32'(el));
      chk({tag, ".busy"},   32'(b5.busy),   32'(eb));
   endtask

   initial begin
      rst_n    = 1'b0;
      b4.mode  = 1'b0;  b4.sel = 2'd2;  b4.d_in = 32'h44332211;
      b4.start = 1'b0;  b4.ready = 1'b0;
      b5.mode  = 1'b0;  b5.sel = 3'd7;  b5.d_in = 40'h5544332211;
      b5.start = 1'b0;  b5.ready = 1'b0;
`ifdef MUX_NT1_SEQ_MASK_EN
      b4.en_mask = 4'b1111;
      b5.en_mask = 5'b11111;
`endif
      #12;
      chk4("reset4", 32'h00, 0, 1'b0, 1'b0, 1'b0);
      chk5("reset5", 32'h00, 0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Direct mode, one-cycle latency; READY ignored.
      tick();
      chk4("direct_sel2", 32'h33, 2, 1'b1, 1'b0, 1'b0);
      chk5("direct5_sel7", 32'h00, 7, 1'b0, 1'b0, 1'b0);
      b4.sel = 2'd0; b4.ready = 1'b1; b5.sel = 3'd4;
      tick();
      chk4("direct_sel0", 32'h11, 0, 1'b1, 1'b0, 1'b0);
      chk5("direct5_sel4", 32'h55, 4, 1'b1, 1'b0, 1'b0);
      b4.sel = 2'd3; b5.sel = 3'd7;
      tick();
      chk4("direct_sel3", 32'h44, 3, 1'b1, 1'b0, 1'b0);
      chk5("direct5_oor", 32'h00, 7, 1'b0, 1'b0, 1'b0);

      // Scan mode idle, then a full scan with READY high.
      b4.mode = 1'b1; b4.sel = 2'd1;
      tick();
      chk4("scan_idle", 32'h44, 3, 1'b0, 1'b0, 1'b0);
      b4.start = 1'b1;
      tick();
      b4.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk4($sformatf("scan_b%0d", k), 32'((k + 1) * 17), 32'(k), 1'b1, (k == 3), 1'b1);
         tick();
      end
      chk4("scan_end", 32'h44, 3, 1'b0, 1'b0, 1'b0);

      // Backpressure on beat 2 while channel 1 changes.
      b4.start = 1'b1;
      tick();
      b4.start = 1'b0;
      chk4("bp_b0", 32'h11, 0, 1'b1, 1'b0, 1'b1);
      tick();
      chk4("bp_b1", 32'h22, 1, 1'b1, 1'b0, 1'b1);
      b4.ready = 1'b0;
      b4.d_in[15:8] = 8'h99;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk4($sformatf("bp_hold%0d", k), 32'h22, 1, 1'b1, 1'b0, 1'b1);
      end
      b4.ready = 1'b1; b4.mode = 1'b0; b4.start = 1'b1;
      tick();
      chk4("bp_b2_ign", 32'h33, 2, 1'b1, 1'b0, 1'b1);
      b4.mode = 1'b1;
      tick();
      chk4("bp_b3", 32'h44, 3, 1'b1, 1'b1, 1'b1);
      tick();
      chk4("start_at_last", 32'h44, 3, 1'b0, 1'b0, 1'b0);
      tick();
      b4.start = 1'b0;
      chk4("restart_b0", 32'h11, 0, 1'b1, 1'b0, 1'b1);
      tick();
      chk4("restart_b1", 32'h99, 1, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset mid-scan.
      #1 rst_n = 1'b0;
      #1 chk4("rst_mid", 32'h00, 0, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      tick();
      chk4("rst_after1", 32'h00, 0, 1'b0, 1'b0, 1'b0);
      tick();
      chk4("rst_after2", 32'h00, 0, 1'b0, 1'b0, 1'b0);

      // N=5 scan: five beats, LAST on channel 4.
      b5.mode = 1'b1; b5.ready = 1'b1; b5.start = 1'b1;
      tick();
      b5.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk5($sformatf("scan5_b%0d", k), 32'((k + 1) * 17), 32'(k), 1'b1, (k == 4), 1'b1);
         tick();
      end
      chk5("scan5_end", 32'h55, 4, 1'b0, 1'b0, 1'b0);

`ifdef MUX_NT1_SEQ_MASK_EN
      b4.d_in = 32'h44332211;
      b4.en_mask = 4'b1010; b4.start = 1'b1;
      tick();
      b4.start = 1'b0; b4.en_mask = 4'b1111;
      chk4("mask_b0", 32'h22, 1, 1'b1, 1'b0, 1'b1);
      tick();
      chk4("mask_b1", 32'h44, 3, 1'b1, 1'b1, 1'b1);
      tick();
      chk4("mask_end", 32'h44, 3, 1'b0, 1'b0, 1'b0);
      b4.en_mask = 4'b0000; b4.start = 1'b1;
      tick();
      chk4("mask_zero1", 32'h44, 3, 1'b0, 1'b0, 1'b0);
      tick();
      chk4("mask_zero2", 32'h44, 3, 1'b0, 1'b0, 1'b0);
      b4.start = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
